// File: rtl/cdc_2phase_dst_clearable.sv
// Destination half of a clearable two-phase clock domain crossing.
// Synchronizes the toggling request and captures the source data into a
// 2-entry buffer presented on a valid/ready interface. Each captured item
// is acknowledged by toggling async_ack_o. A synchronous clear flushes the
// buffer, drops the acknowledge to 0 and holds off capture until the
// request synchronizer has settled.
module cdc_2phase_dst_clearable #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             async_req_i,
    output logic             async_ack_o,
    input  logic [WIDTH-1:0] async_data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o
);

    localparam int HOLD_W = $clog2(SYNC_STAGES + 2);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(SYNC_STAGES + 1);

    typedef enum logic {
        ST_RUN,
        ST_HOLD
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [HOLD_W-1:0]  r_holdCnt;
    logic [HOLD_W-1:0]  w_holdCntNext;

    logic [SYNC_STAGES-1:0] r_reqSync;
    logic                   w_reqSynced;

    logic             r_ackQ;
    logic [WIDTH-1:0] r_mem [2];
    logic             r_rdPtr;
    logic             r_wrPtr;
    logic [1:0]       r_count;

    logic w_pending;
    logic w_pop;
    logic w_push;

    // Request synchronizer; deliberately untouched by clear so it keeps tracking the source.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_reqSync <= '0;
        end else begin
            r_reqSync <= {r_reqSync[SYNC_STAGES-2:0], async_req_i};
        end
    end

    assign w_reqSynced = r_reqSync[SYNC_STAGES-1];

    // Handshake decode: a pending item is pushed when there is room or the head leaves this cycle.
    always_comb begin
        w_pending = (w_reqSynced != r_ackQ);
        w_pop     = valid_o && ready_i;
        w_push    = w_pending && (r_state == ST_RUN) && ((r_count != 2'd2) || w_pop);
    end

    // FSM state and settle counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_RUN;
            r_holdCnt <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_holdCnt <= w_holdCntNext;
        end
    end

    // Next state: clear enters HOLD and reloads; HOLD counts down, then returns to RUN.
    always_comb begin
        w_stateNext   = r_state;
        w_holdCntNext = r_holdCnt;
        if (clear_i) begin
            w_stateNext   = ST_HOLD;
            w_holdCntNext = HOLD_LOAD;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_holdCnt == '0) begin
                        w_stateNext = ST_RUN;
                    end else begin
                        w_holdCntNext = r_holdCnt - HOLD_W'(1);
                    end
                end
                default: begin
                    w_stateNext = r_state;
                end
            endcase
        end
    end

    // Buffer pointers, occupancy and acknowledge; clear overrides push and pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ackQ  <= 1'b0;
            r_rdPtr <= 1'b0;
            r_wrPtr <= 1'b0;
            r_count <= 2'd0;
        end else if (clear_i) begin
            r_ackQ  <= 1'b0;
            r_rdPtr <= 1'b0;
            r_wrPtr <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_wrPtr <= ~r_wrPtr;
                r_ackQ  <= ~r_ackQ;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents survive clear since they are unreachable until rewritten.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!clear_i && w_push) begin
            r_mem[r_wrPtr] <= async_data_i;
        end
    end

    assign async_ack_o = r_ackQ;
    assign valid_o     = (r_count != 2'd0);
    assign data_o      = r_mem[r_rdPtr];

`ifndef SYNTHESIS
    logic             r_chkArm;
    logic [WIDTH-1:0] r_chkData;

    // Remember whether the head was stalled last cycle so it can be checked for stability.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_chkArm  <= 1'b0;
            r_chkData <= '0;
        end else begin
            r_chkArm  <= valid_o && !ready_i && !clear_i;
            r_chkData <= data_o;
        end
    end

    a_validHeld : assert property (@(posedge clk_i) r_chkArm |-> valid_o);
    a_dataHeld  : assert property (@(posedge clk_i) r_chkArm |-> (data_o == r_chkData));
`endif

endmodule

// File: tb/tb_cdc_2phase_dst_clearable.sv
// Self-checking bench for cdc_2phase_dst_clearable: directed latency,
// back-pressure, clear and reset scenarios plus a randomized stream from an
// asynchronous source, all checked through an in-order scoreboard.
module tb_cdc_2phase_dst_clearable;

   localparam int WIDTH      = 4;
   localparam int SYNC       = 2;
   localparam int NUM_RANDOM = 1000;

   logic             clk_i  = 1'b0;
   logic             srcClk = 1'b0;
   logic             rst_i;
   logic             clear_i;
   logic             async_req_i;
   logic             async_ack_o;
   logic [WIDTH-1:0] async_data_i;
   logic             valid_o;
   logic             ready_i;
   logic [WIDTH-1:0] data_o;

   int checks        = 0;
   int errors        = 0;
   int rxCount       = 0;
   int acceptedTotal = 0;
   bit randDone      = 1'b0;
   logic [WIDTH-1:0] expQ [$];

   cdc_2phase_dst_clearable #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .clear_i      (clear_i),
      .async_req_i  (async_req_i),
      .async_ack_o  (async_ack_o),
      .async_data_i (async_data_i),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .data_o       (data_o)
   );

   // Destination clock, period 20, edges on even times.
   initial forever #10 clk_i = ~clk_i;

   // Source clock, period 34 (1.7x), rising edges on odd times so they never meet a destination edge.
   initial begin
      #4;
      forever #17 srcClk = ~srcClk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic failTimeout(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: timed out, got no response expected a response", name);
   endtask

   task automatic stepDst();
      @(posedge clk_i);
      #1;
   endtask

   // Source model step: present data, toggle request, record the expected item.
   task automatic applyStimulus(input logic [WIDTH-1:0] d, input bit waitAck);
      async_data_i = d;
      async_req_i  = ~async_req_i;
      expQ.push_back(d);
      if (waitAck) begin
         int guard = 0;
         acceptedTotal++;
         while (async_ack_o !== async_req_i && guard < 50) begin
            stepDst();
            guard++;
         end
         if (async_ack_o !== async_req_i) failTimeout("ack return");
      end
   endtask

   task automatic waitDrain(input int bound);
      int g = 0;
      while (expQ.size() != 0 && g < bound) begin
         stepDst();
         g++;
      end
      if (expQ.size() != 0) failTimeout("scoreboard drain");
   endtask

   // Scoreboard monitor: every accepted head item must match the oldest issued item.
   task automatic monitorLoop();
      forever begin
         @(negedge clk_i);
         if (rst_i === 1'b0 && valid_o === 1'b1 && ready_i === 1'b1) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL scoreboard: got unexpected item %0h expected none", data_o);
            end else begin
               logic [WIDTH-1:0] e;
               e = expQ.pop_front();
               checkOutput("scoreboard data", 32'(data_o), 32'(e));
               rxCount++;
            end
         end
      end
   endtask

   // Asynchronous source: waits for its own synchronized view of ack before each new toggle.
   task automatic srcRandom(input int n);
      logic a1;
      logic a2;
      int   guard;
      a1 = async_ack_o;
      a2 = async_ack_o;
      for (int i = 0; i < n; i++) begin
         guard = 0;
         while (a2 !== async_req_i && guard < 400) begin
            @(posedge srcClk);
            a2 = a1;
            a1 = async_ack_o;
            guard++;
         end
         if (a2 !== async_req_i) begin
            failTimeout("source ack wait");
            break;
         end
         repeat ($urandom_range(0, 2)) begin
            @(posedge srcClk);
            a2 = a1;
            a1 = async_ack_o;
         end
         @(posedge srcClk);
         a2 = a1;
         a1 = async_ack_o;
         #2;
         async_data_i = WIDTH'($urandom);
         async_req_i  = ~async_req_i;
         expQ.push_back(async_data_i);
      end
      randDone = 1'b1;
   endtask

   task automatic readyLoop();
      while (!randDone) begin
         stepDst();
         ready_i = ($urandom_range(0, 3) != 0);
      end
      ready_i = 1'b1;
   endtask

   initial begin
      rst_i        = 1'b1;
      clear_i      = 1'b0;
      async_req_i  = 1'b0;
      async_data_i = '0;
      ready_i      = 1'b1;

      fork
         monitorLoop();
      join_none

      repeat (3) @(posedge clk_i);
      #1;
      checkOutput("reset valid", 32'(valid_o), 0);
      checkOutput("reset ack", 32'(async_ack_o), 0);
      checkOutput("reset data", 32'(data_o), 0);
      rst_i = 1'b0;

      // Latency: toggle just after edge 0, item appears at edge SYNC+1.
      stepDst();
      applyStimulus(4'h5, 1'b0);
      acceptedTotal++;
      stepDst();
      stepDst();
      checkOutput("edge2 valid", 32'(valid_o), 0);
      checkOutput("edge2 ack", 32'(async_ack_o), 0);
      stepDst();
      checkOutput("edge3 valid", 32'(valid_o), 1);
      checkOutput("edge3 data", 32'(data_o), 32'h5);
      checkOutput("edge3 ack", 32'(async_ack_o), 32'(acceptedTotal[0]));
      waitDrain(20);

      // Back-pressure: two items buffered, third left pending.
      ready_i = 1'b0;
      applyStimulus(4'h1, 1'b1);
      applyStimulus(4'h2, 1'b1);
      applyStimulus(4'h3, 1'b0);
      repeat (10) stepDst();
      checkOutput("pending ack held", 32'(async_ack_o), 32'(acceptedTotal[0]));
      checkOutput("full valid", 32'(valid_o), 1);
      checkOutput("full head", 32'(data_o), 32'h1);

      // Pop and push on the same edge at count 2.
      ready_i = 1'b1;
      stepDst();
      acceptedTotal++;
      checkOutput("pop+push ack", 32'(async_ack_o), 32'(acceptedTotal[0]));
      checkOutput("pop+push valid", 32'(valid_o), 1);
      checkOutput("pop+push head", 32'(data_o), 32'h2);
      waitDrain(50);

      // Clear with a full buffer and ack at 1.
      applyStimulus(4'h7, 1'b1);
      waitDrain(20);
      ready_i = 1'b0;
      applyStimulus(4'h8, 1'b1);
      applyStimulus(4'h9, 1'b1);
      checkOutput("ack before clear", 32'(async_ack_o), 32'(acceptedTotal[0]));
      clear_i = 1'b1;
      expQ.delete();
      acceptedTotal = 0;
      stepDst();
      clear_i = 1'b0;
      checkOutput("clear valid", 32'(valid_o), 0);
      checkOutput("clear ack", 32'(async_ack_o), 0);
      for (int k = 1; k <= 3; k++) begin
         stepDst();
         checkOutput("hold valid", 32'(valid_o), 0);
         checkOutput("hold ack", 32'(async_ack_o), 0);
         if (k == 2) async_req_i = 1'b0;
      end
      repeat (10) stepDst();
      checkOutput("no phantom valid", 32'(valid_o), 0);
      checkOutput("no phantom ack", 32'(async_ack_o), 0);
      ready_i = 1'b1;

      // Randomized stream from the asynchronous source.
      rxCount  = 0;
      randDone = 1'b0;
      fork
         srcRandom(NUM_RANDOM);
         readyLoop();
      join
      waitDrain(200);
      checkOutput("random item count", 32'(rxCount), 32'(NUM_RANDOM));
      checkOutput("random queue empty", 32'(expQ.size()), 0);

      // Asynchronous reset between edges with one item buffered.
      stepDst();
      ready_i = 1'b0;
      applyStimulus(4'hA, 1'b1);
      @(posedge clk_i);
      #7;
      rst_i = 1'b1;
      #1;
      checkOutput("async reset valid", 32'(valid_o), 0);
      checkOutput("async reset ack", 32'(async_ack_o), 0);
      checkOutput("async reset data", 32'(data_o), 0);
      async_req_i = 1'b0;
      expQ.delete();
      acceptedTotal = 0;
      stepDst();
      stepDst();
      rst_i   = 1'b0;
      ready_i = 1'b1;
      stepDst();
      applyStimulus(4'hC, 1'b1);
      waitDrain(50);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cdc_2phase_dst_clearable.md
# cdc_2phase_dst_clearable

Destination half of the clearable two-phase clock domain crossing. It receives the toggling request and stable data from the source half, synchronizes the request, and presents each item on a valid/ready interface through a 2-entry output buffer. It returns a toggled acknowledge for every item it accepts. A synchronous clear flushes the buffer, returns the acknowledge line to 0 and blocks capture until the request synchronizer has settled.

## Interface
- `WIDTH`, default 1: data width in bits.
- `SYNC_STAGES`, default 2: flip-flop stages in the request synchronizer, ≥2.

- `clk_i` input 1: destination clock; the block has one clock.
- `rst_i` input 1: reset, asynchronous and active-high.
- `clear_i` input 1: synchronous clear, level-sensitive.
- `async_req_i` input 1: two-phase request from the source domain; each toggle is one item.
- `async_ack_o` output 1: two-phase acknowledge to the source domain, driven directly from a flop.
- `async_data_i` input WIDTH: item data, held stable by the source from the request toggle until the acknowledge returns.
- `valid_o` output 1: buffer head holds an item.
- `ready_i` input 1: downstream accepts the head item.
- `data_o` output WIDTH: head item data.

## Operation
- Synchronizer:
  - `async_req_i` passes through `SYNC_STAGES` flops, all reset to 0, giving `req_synced`.
  - The synchronizer is not affected by `clear_i`.
- Acknowledge:
  - Flop `ack_q`, reset 0; `async_ack_o = ack_q`.
  - An item is pending when `req_synced != ack_q`.
- Buffer:
  - 2-entry FIFO with read pointer, write pointer and count (0..2).
  - `valid_o = (count != 0)`; `data_o` is the entry at the read pointer.
- Pop: `valid_o && ready_i`.
- Push condition: pending, and not in HOLD, and (count < 2, or count == 2 with a pop in the same cycle).
- On push:
  - `async_data_i` is written at the write pointer.
  - The write pointer increments, wrapping 1→0.
  - `ack_q` toggles.
- Count:
  - Push without pop: count +1.
  - Pop without push: count −1.
  - Push and pop together: count unchanged.
- Full buffer: when count is 2 and there is no pop, a pending item is left pending. The acknowledge is withheld, which back-pressures the source.
- FSM:
  - RUN: normal operation.
  - HOLD: a counter loads `SYNC_STAGES+1` and decrements once per cycle while `clear_i` is low. The FSM goes to RUN the cycle after the counter reaches 0.
  - Any state with `clear_i` high: go to HOLD, reload the counter, set count to 0, reset both pointers to 0, set `ack_q` to 0.
  - Clear takes priority over push and pop in the same cycle.
  - While in HOLD: no push; `valid_o` is 0.
- Clear is used together with the source-half clear. After both sides have cleared, req and ack both settle at 0 with no phantom item.
- Reset `rst_i` high:
  - `ack_q` = 0, count = 0, pointers = 0, synchronizer flops = 0, storage = 0.
  - FSM enters RUN.
  - Outputs: `async_ack_o` = 0, `valid_o` = 0, `data_o` = 0.
- Storage is not cleared by `clear_i`. `data_o` is don't-care while `valid_o` is 0.
- Assertions, simulation only:
  - `valid_o` falling without a pop or clear is an error.
  - `data_o` changing while `valid_o && !ready_i` is an error.

## Timing
- Request toggle sampled at edge 0 → `req_synced` changes after `SYNC_STAGES` edges.
- Push happens on the next edge: `valid_o` rises and `async_ack_o` toggles at edge `SYNC_STAGES+1`, which is edge 3 for the default.
- Throughput: one item per source round trip. The buffer never limits throughput while downstream is ready.
- Pop takes effect at the clock edge. Simultaneous push and pop at count 2 is a legal back-to-back transfer.
- `clear_i` high at edge N → `valid_o` = 0 and `async_ack_o` = 0 from edge N.
- First possible push after `clear_i` falls is at edge `SYNC_STAGES+2` or later.
- Reset asserted mid-transfer: all state returns to reset values immediately. The source must be reset or cleared alongside.

## Test plan
- Reset, then toggle `async_req_i` 0→1 with data 0x5 (WIDTH=4), `ready_i`=1 → `valid_o`=1 and `data_o`=0x5 at edge 3; `async_ack_o`=1 at edge 3.
- `ready_i`=0, source sends 0x1, 0x2, 0x3 → first two are acknowledged and buffered. The third stays pending with `async_ack_o` unchanged. Raise `ready_i` → outputs 0x1, 0x2, 0x3 in order, then a third ack toggle.
- Count 2, pop on the same edge as a pending push → count stays 2, ack toggles, head advances to the next item.
- `clear_i` for 1 cycle while count is 2 and ack is 1 → `valid_o`=0 and `async_ack_o`=0 the same edge. No push for 3 cycles even with `async_req_i`=1; the source clears to 0 and no phantom item appears.
- 1000 random items, random `ready_i`, source at an asynchronous 1.7× clock → output sequence matches input exactly, with no drops or duplicates.
- `rst_i` asserted asynchronously between edges with count 1 → `valid_o`, `async_ack_o` and `data_o` go to 0 without waiting for a clock edge.
